// File: rtl/alu_req_server_pkg.sv
// Shared ALU opcode and SET-family codes plus the response-slot state type.
// The testbench and the CPU control unit use the same constants.
`default_nettype none

package alu_req_server_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SET  = 4'd7;
  localparam logic [3:0] ALU_NOR  = 4'd12;
  localparam logic [3:0] ALU_NAND = 4'd13;

  localparam logic [2:0] BON_SLT = 3'd0;
  localparam logic [2:0] BON_SGT = 3'd1;
  localparam logic [2:0] BON_SLE = 3'd2;
  localparam logic [2:0] BON_SGE = 3'd3;
  localparam logic [2:0] BON_SNE = 3'd4;
  localparam logic [2:0] BON_SEQ = 3'd6;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_core.sv
// Combinational lab ALU: result, {zero, cout, overflow} and illegal-code flag.
`default_nettype none

module alu_core
  import alu_req_server_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       alu_control,
  input  logic [2:0]       bonus_control,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       zcv,
  output logic             illegal
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic           add_ovf;
  logic           sub_ovf;
  logic           lt;
  logic           eq;
  logic           cond;
  logic           cout;
  logic           ovf;

  assign add_full = {1'b0, src1} + {1'b0, src2};
  assign sub_full = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf  = (src1[MSB] == src2[MSB]) && (add_full[MSB] != src1[MSB]);
  assign sub_ovf  = (src1[MSB] != src2[MSB]) && (sub_full[MSB] != src1[MSB]);
  // Signed less-than stays correct even when the subtraction overflows.
  assign lt       = sub_full[MSB] ^ sub_ovf;
  assign eq       = (src1 == src2);

  always_comb begin
    result  = '0;
    cout    = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    cond    = 1'b0;
    case (alu_control)
      ALU_AND:  result = src1 & src2;
      ALU_OR:   result = src1 | src2;
      ALU_NOR:  result = ~(src1 | src2);
      ALU_NAND: result = ~(src1 & src2);
      ALU_ADD: begin
        result = add_full[MSB:0];
        cout   = add_full[WIDTH];
        ovf    = add_ovf;
      end
      ALU_SUB: begin
        result = sub_full[MSB:0];
        cout   = sub_full[WIDTH];
        ovf    = sub_ovf;
      end
      ALU_SET: begin
        case (bonus_control)
          BON_SLT: cond = lt;
          BON_SGT: cond = !lt && !eq;
          BON_SLE: cond = lt || eq;
          BON_SGE: cond = !lt;
          BON_SNE: cond = !eq;
          BON_SEQ: cond = eq;
          default: illegal = 1'b1;
        endcase
        result = {{(WIDTH-1){1'b0}}, cond};
      end
      default: illegal = 1'b1;
    endcase
  end

  assign zcv = {(result == '0), cout, ovf};

endmodule

`default_nettype wire

// File: rtl/alu_req_server.sv
// Handshaked, registered ALU responder: one-entry output slot, latency 1,
// full throughput, plus a delivered-operation counter.
`default_nettype none

module alu_req_server
  import alu_req_server_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_src1,
  input  logic [WIDTH-1:0] req_src2,
  input  logic [3:0]       req_alu_control,
  input  logic [2:0]       req_bonus_control,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [2:0]       rsp_zcv,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count
);

  rsp_state_t       state;
  rsp_state_t       state_next;
  logic             accept;
  logic             deliver;
  logic [WIDTH-1:0] core_result;
  logic [2:0]       core_zcv;
  logic             core_illegal;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .src1         (req_src1),
    .src2         (req_src2),
    .alu_control  (req_alu_control),
    .bonus_control(req_bonus_control),
    .result       (core_result),
    .zcv          (core_zcv),
    .illegal      (core_illegal)
  );

  // Ready depends only on slot state and the consumer, never on req_valid.
  assign req_ready = (state == ST_EMPTY) | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign deliver   = (state == ST_FULL) & rsp_ready;
  assign rsp_valid = (state == ST_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (deliver && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result  <= '0;
      rsp_zcv     <= '0;
      rsp_illegal <= 1'b0;
    end else if (accept) begin
      rsp_result  <= core_result;
      rsp_zcv     <= core_zcv;
      rsp_illegal <= core_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (deliver) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

`default_nettype wire
